// File: rtl/wishbone_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | wishbone_arbiter_pkg: shared types for the WISHBONE bus arbiter     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package wishbone_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of the stb-without-ack counter; kept at least 1 so a disabled watchdog still elaborates.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wishbone_arbiter_rr_priority_picker.sv
// +--------------------------------------------------------------------+
// | rr_priority_picker: round-robin pick of the first requester after   |
// | the last owner. Purely combinational. rev 1.0                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!found && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt[IDX_W'(cand)]    = 1'b1;
        gnt_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wishbone_arbiter.sv
// +--------------------------------------------------------------------+
// | wishbone_arbiter: round-robin sharing of one WISHBONE slave port,   |
// | grant held per cycle (cyc), stb watchdog raising err. rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int PORT_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*PORT_SIZE-1:0] m_adr_i,
  input  logic [NUM_MASTERS*PORT_SIZE-1:0] m_dat_i,
  output logic [PORT_SIZE-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [NUM_MASTERS-1:0]           grant_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [PORT_SIZE-1:0]             s_adr_o,
  output logic [PORT_SIZE-1:0]             s_dat_o,
  input  logic [PORT_SIZE-1:0]             s_dat_i,
  input  logic                             s_ack_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   busy;
  logic                   owner_cyc;
  logic                   stb_fwd;
  logic                   err_pulse;

  rr_priority_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (m_cyc_i),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  assign busy      = (state_q == BUSY);
  assign owner_cyc = m_cyc_i[owner_q];
  // The err cycle withholds stb so the slave cannot complete the timed-out transfer late.
  assign stb_fwd   = busy & owner_cyc & m_stb_i[owner_q] & ~err_pulse;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = busy & owner_cyc;
    s_stb_o = stb_fwd;
    s_we_o  = busy & m_we_i[owner_q];
    s_adr_o = busy ? m_adr_i[int'(owner_q)*PORT_SIZE +: PORT_SIZE] : '0;
    s_dat_o = busy ? m_dat_i[int'(owner_q)*PORT_SIZE +: PORT_SIZE] : '0;
    grant_o = grant_q;
    m_ack_o = '0;
    m_err_o = '0;
    if (stb_fwd && s_ack_i) begin
      m_ack_o[owner_q] = 1'b1;
    end
    if (busy && err_pulse) begin
      m_err_o[owner_q] = 1'b1;
    end
    m_dat_o = wb_rst_n_i ? s_dat_i : '0;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             err_q, err_d;

      // Counts consecutive stalled stb cycles; stb low (including leaving BUSY) restarts it.
      always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (stb_fwd && !s_ack_i) begin
          if (cnt_q == CNT_LAST) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          err_q <= err_d;
        end
      end

      assign err_pulse = err_q;
    end else begin : g_no_watchdog
      assign err_pulse = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_wishbone_arbiter: scoreboard bench for wishbone_arbiter with a   |
// | transaction-level reference model. rev 1.0                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_wishbone_arbiter;

  localparam int N = 2;
  localparam int W = 8;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   cyc, stb, we;
  logic [N*W-1:0] adr, dat;
  logic [W-1:0]   sdat;
  logic           ack;

  logic [W-1:0]   m_dat_o;
  logic [N-1:0]   m_ack_o, m_err_o, grant_o;
  logic           s_cyc_o, s_stb_o, s_we_o;
  logic [W-1:0]   s_adr_o, s_dat_o;

  always #5 clk = ~clk;

  wishbone_arbiter #(
    .NUM_MASTERS    (N),
    .PORT_SIZE      (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_cyc_i    (cyc),
    .m_stb_i    (stb),
    .m_we_i     (we),
    .m_adr_i    (adr),
    .m_dat_i    (dat),
    .m_dat_o    (m_dat_o),
    .m_ack_o    (m_ack_o),
    .m_err_o    (m_err_o),
    .grant_o    (grant_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_dat_i    (sdat),
    .s_ack_i    (ack)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] mack;
    logic [N-1:0] merr;
    logic         scyc;
    logic         sstb;
    logic         swe;
    logic [W-1:0] sadr;
    logic [W-1:0] sdat;
    logic [W-1:0] mdat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: who owns the bus, who owned it last, stalled-stb run length, err pending.
  bit   mdl_busy;
  int   mdl_owner;
  int   mdl_last;
  int   mdl_stall;
  bit   mdl_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_owner = 0;
    mdl_last  = N - 1;
    mdl_stall = 0;
    mdl_err   = 1'b0;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; ack = 1'b0; sdat = '0;
  endtask

  task automatic set_m(input int i, input bit c, input bit s, input bit w,
                       input logic [W-1:0] a, input logic [W-1:0] d);
    cyc[i] = c; stb[i] = s; we[i] = w;
    adr[i*W +: W] = a;
    dat[i*W +: W] = d;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
  task automatic step();
    exp_t e;
    bit   stb_live;
    bit   n_busy, n_err;
    int   n_owner, n_last, n_stall;
    e        = '0;
    e.mdat   = sdat;
    stb_live = 1'b0;
    n_busy = mdl_busy; n_owner = mdl_owner; n_last = mdl_last; n_stall = 0; n_err = 1'b0;
    if (mdl_busy) begin
      stb_live = cyc[mdl_owner] && stb[mdl_owner] && !mdl_err;
      e.grant  = N'(1) << mdl_owner;
      e.scyc   = cyc[mdl_owner];
      e.sstb   = stb_live;
      e.swe    = we[mdl_owner];
      e.sadr   = adr[mdl_owner*W +: W];
      e.sdat   = dat[mdl_owner*W +: W];
      if (stb_live && ack) e.mack = N'(1) << mdl_owner;
      if (mdl_err)         e.merr = N'(1) << mdl_owner;
      if (stb_live && !ack) begin
        if (mdl_stall == T - 1) n_err = 1'b1;
        else                    n_stall = mdl_stall + 1;
      end
      if (!cyc[mdl_owner]) begin
        n_busy = 1'b0;
        n_last = mdl_owner;
      end
    end else if (cyc != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c = (mdl_last + k) % N;
        if (!n_busy && cyc[c]) begin
          n_busy  = 1'b1;
          n_owner = c;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    mdl_busy = n_busy; mdl_owner = n_owner; mdl_last = n_last;
    mdl_stall = n_stall; mdl_err = n_err;
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant_o", 32'(grant_o), 32'(e.grant));
      check("m_ack_o", 32'(m_ack_o), 32'(e.mack));
      check("m_err_o", 32'(m_err_o), 32'(e.merr));
      check("s_cyc_o", 32'(s_cyc_o), 32'(e.scyc));
      check("s_stb_o", 32'(s_stb_o), 32'(e.sstb));
      check("s_we_o",  32'(s_we_o),  32'(e.swe));
      check("s_adr_o", 32'(s_adr_o), 32'(e.sadr));
      check("s_dat_o", 32'(s_dat_o), 32'(e.sdat));
      check("m_dat_o", 32'(m_dat_o), 32'(e.mdat));
    end
  end

  // Asserts reset between clock edges, checks the asynchronous drop, releases off-edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_s_stb", 32'(s_stb_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_m_ack", 32'(m_ack_o), 32'd0);
    check("rst_m_err", 32'(m_err_o), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_run(input bit late_ack);
    set_m(0, 1, 1, 0, 8'h55, 8'h00);
    ack = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      ack = late_ack && (i == T);
      step();
    end
    set_m(0, 0, 0, 0, 8'h00, 8'h00);
    ack = 1'b0;
    step();
    step();
  endtask

  int  cyc_left[N];
  bit  stb_hold[N];
  bit  hang;

  initial begin
    clear_inputs();
    model_reset();
    #12;
    check("reset_grant", 32'(grant_o), 32'd0);
    check("reset_s_cyc", 32'(s_cyc_o), 32'd0);
    check("reset_m_dat", 32'(m_dat_o), 32'd0);
    #16;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read with a two-clock slave.
    set_m(0, 1, 1, 0, 8'h12, 8'h00);
    step();
    step();
    ack = 1'b1; sdat = 8'hA5;
    step();
    set_m(0, 0, 0, 0, 8'h00, 8'h00);
    ack = 1'b0;
    step();
    step();

    // Simultaneous requests alternate after a fresh reset.
    async_reset();
    for (int k = 0; k < 8; k++) begin
      cyc = '1; stb = '1; ack = 1'b0;
      step();
      ack = 1'b1; sdat = W'(k);
      step();
      cyc[k % 2] = 1'b0; stb[k % 2] = 1'b0; ack = 1'b0;
      step();
    end

    // Read-modify-write by m1 while m0 keeps requesting.
    clear_inputs();
    set_m(1, 1, 1, 0, 8'h40, 8'h00);
    step();
    set_m(0, 1, 1, 0, 8'h20, 8'h11);
    ack = 1'b1; sdat = 8'h77;
    step();
    stb[1] = 1'b0; ack = 1'b0;
    step();
    set_m(1, 1, 1, 1, 8'h40, 8'h3C);
    ack = 1'b1;
    step();
    set_m(1, 0, 0, 0, 8'h00, 8'h00);
    ack = 1'b0;
    step();
    step();
    ack = 1'b1;
    step();
    set_m(0, 0, 0, 0, 8'h00, 8'h00);
    ack = 1'b0;
    step();
    step();

    // Hung slave, then an ack that lands on the err cycle.
    stall_run(1'b0);
    stall_run(1'b1);

    // Reset in the middle of a write, then m0 priority on simultaneous requests.
    set_m(0, 1, 1, 1, 8'h33, 8'h99);
    step();
    step();
    check("pre_rst_s_cyc", 32'(s_cyc_o), 32'd1);
    check("pre_rst_s_stb", 32'(s_stb_o), 32'd1);
    async_reset();
    cyc = '1; stb = '1;
    step();
    ack = 1'b1;
    step();
    cyc[0] = 1'b0; stb[0] = 1'b0; ack = 1'b0;
    step();
    step();
    ack = 1'b1;
    step();
    clear_inputs();
    step();

    // Randomised traffic with a slave that is sometimes responsive, sometimes hung.
    for (int i = 0; i < N; i++) begin cyc_left[i] = 0; stb_hold[i] = 1'b0; end
    hang = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) hang = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < N; i++) begin
        if (cyc_left[i] == 0 && $urandom_range(0, 3) == 0) begin
          stb_hold[i] = ($urandom_range(0, 9) == 0);
          cyc_left[i] = stb_hold[i] ? 24 : int'($urandom_range(1, 8));
        end
        cyc[i] = (cyc_left[i] > 0);
        stb[i] = cyc[i] && (stb_hold[i] || $urandom_range(0, 3) != 0);
        we[i]  = 1'($urandom);
        adr[i*W +: W] = W'($urandom);
        dat[i*W +: W] = W'($urandom);
        if (cyc_left[i] > 0) cyc_left[i]--;
      end
      ack  = !hang && ($urandom_range(0, 2) == 0);
      sdat = W'($urandom);
      step();
    end
    clear_inputs();
    step();
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
